// File: rtl/acq_pkg.sv
// acq_pkg: shared encodings for the SPI ADC acquisition scheduler.
// Holds the FSM state type and the continuous-run sample-count code.
package acq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_TICK = 3'd1,
      ST_FIRE      = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_FINISH    = 3'd4
   } acq_state_e;

   localparam int unsigned NSAMP_CONTINUOUS = 0;

endpackage

// File: rtl/acq_scheduler_period_tick.sv
// period_tick: reload down-counter producing the sample-period tick.
// Ticks (zero_o) every val_i+1 enabled cycles after a load.
module period_tick
   import acq_pkg::*;
#(
   parameter int unsigned Width = 29
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             en_i,
   input  logic [Width-1:0] val_i,
   output logic             zero_o
);

   logic [Width-1:0] cnt_q;
   logic [Width-1:0] cnt_d;

   // Load wins; otherwise count down and wrap to the reload value at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = val_i;
      end else if (en_i) begin
         if (cnt_q == '0) begin
            cnt_d = val_i;
         end else begin
            cnt_d = cnt_q - Width'(1);
         end
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/acq_scheduler.sv
// acq_scheduler: periodic SPI ADC acquisition sequencer.
// Fires one SPI transfer per period tick, counts samples, flags overrun/timeout.
module acq_scheduler
   import acq_pkg::*;
#(
   parameter int unsigned Width  = 29,
   parameter int unsigned NSampW = 16,
   parameter int unsigned ToutW  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic [Width-1:0]  period_i,
   input  logic [NSampW-1:0] nsamp_i,
   input  logic [ToutW-1:0]  tout_i,
   output logic              spi_start_o,
   input  logic              spi_done_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              ovr_o,
   output logic              tout_o,
   output logic [NSampW-1:0] cnt_o
);

   acq_state_e        state_q;
   logic [Width-1:0]  per_q;
   logic [NSampW-1:0] nsamp_q;
   logic [NSampW-1:0] cnt_q;
   logic [ToutW-1:0]  tcfg_q;
   logic [ToutW-1:0]  tcnt_q;
   logic              stop_q;
   logic              spi_start_q;
   logic              busy_q;
   logic              done_q;
   logic              ovr_q;
   logic              tout_q;

   logic              accept;
   logic              pt_en;
   logic              pt_zero;
   logic [Width-1:0]  pt_val;
   logic [NSampW-1:0] cnt_inc;
   logic [NSampW-1:0] cnt_sat;
   logic              last;
   logic              stop_any;

   assign accept   = (state_q == ST_IDLE) && start_i;
   assign pt_en    = (state_q == ST_WAIT_TICK) ||
                     (state_q == ST_FIRE) ||
                     (state_q == ST_WAIT_DONE);
   assign pt_val   = accept ? period_i : per_q;
   assign cnt_inc  = cnt_q + NSampW'(1);
   assign cnt_sat  = (&cnt_q) ? cnt_q : cnt_inc;
   assign last     = (nsamp_q != NSampW'(NSAMP_CONTINUOUS)) &&
                     (cnt_inc == nsamp_q);
   assign stop_any = stop_i || stop_q;

   // The period counter free-runs through the whole run so the tick
   // cadence never depends on SPI latency.
   period_tick #(
      .Width (Width)
   ) u_period (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (accept),
      .en_i   (pt_en),
      .val_i  (pt_val),
      .zero_o (pt_zero)
   );

   // Sequencer FSM with registered strobe, status and sample counter.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         per_q       <= '0;
         nsamp_q     <= '0;
         cnt_q       <= '0;
         tcfg_q      <= '0;
         tcnt_q      <= '0;
         stop_q      <= 1'b0;
         spi_start_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         ovr_q       <= 1'b0;
         tout_q      <= 1'b0;
      end else begin
         spi_start_q <= 1'b0;
         done_q      <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  per_q   <= period_i;
                  nsamp_q <= nsamp_i;
                  tcfg_q  <= tout_i;
                  cnt_q   <= '0;
                  ovr_q   <= 1'b0;
                  tout_q  <= 1'b0;
                  stop_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= ST_WAIT_TICK;
               end
            end
            ST_WAIT_TICK: begin
               if (stop_any) begin
                  stop_q  <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= ST_FINISH;
               end else if (pt_zero) begin
                  spi_start_q <= 1'b1;
                  state_q     <= ST_FIRE;
               end
            end
            ST_FIRE: begin
               if (stop_i) begin
                  stop_q <= 1'b1;
               end
               tcnt_q  <= tcfg_q;
               state_q <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               if (stop_i) begin
                  stop_q <= 1'b1;
               end
               if (spi_done_i) begin
                  cnt_q <= cnt_sat;
                  if (last || stop_any) begin
                     done_q  <= 1'b1;
                     state_q <= ST_FINISH;
                  end else if (pt_zero) begin
                     spi_start_q <= 1'b1;
                     state_q     <= ST_FIRE;
                  end else begin
                     state_q <= ST_WAIT_TICK;
                  end
               end else begin
                  if (pt_zero) begin
                     ovr_q <= 1'b1;
                  end
                  if (tcfg_q != '0) begin
                     tcnt_q <= tcnt_q - ToutW'(1);
                     if (tcnt_q == ToutW'(1)) begin
                        tout_q  <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_FINISH;
                     end
                  end
               end
            end
            ST_FINISH: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign spi_start_o = spi_start_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign ovr_o       = ovr_q;
   assign tout_o      = tout_q;
   assign cnt_o       = cnt_q;

endmodule

// File: tb/tb_acq_scheduler.sv
// tb_acq_scheduler: self-checking bench for acq_scheduler.
// Expected strobe/finish times come from a tick-grid event model.
module tb_acq_scheduler;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        stop_i;
   logic [28:0] period_i;
   logic [15:0] nsamp_i;
   logic [15:0] tout_i;
   logic        spi_start_o;
   logic        spi_done_i;
   logic        busy_o;
   logic        done_o;
   logic        ovr_o;
   logic        tout_o;
   logic [15:0] cnt_o;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   int exp_str[$];
   int exp_end;
   int exp_cnt;
   bit exp_ovr;
   bit exp_tout;

   acq_scheduler dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .stop_i      (stop_i),
      .period_i    (period_i),
      .nsamp_i     (nsamp_i),
      .tout_i      (tout_i),
      .spi_start_o (spi_start_o),
      .spi_done_i  (spi_done_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .ovr_o       (ovr_o),
      .tout_o      (tout_o),
      .cnt_o       (cnt_o)
   );

   always #5 clk = ~clk;

   // Cycle index: value observed between edge n and edge n+1 is cycle n.
   always @(posedge clk) cyc <= cyc + 1;

   // Period ticks land on cycles s+p, s+p+(p+1), ... after start edge s.
   function automatic bit is_tick(int s, int p, int c);
      if (c < s + p) return 1'b0;
      return ((c - s - p) % (p + 1)) == 0;
   endfunction

   function automatic int next_tick(int s, int p, int c);
      int k;
      if (c <= s + p) return s + p;
      k = (c - s - p + p) / (p + 1);
      return s + p + k * (p + 1);
   endfunction

   // Event model: walks tick grid, SPI latency, timeout and stop rules.
   task automatic model(input int s, input int p, input int n,
                        input int t, input int l, input int stop_c,
                        input bit resp);
      int from;
      int f;
      int d;
      int cnt;
      int guard;
      bit fin;
      exp_str.delete();
      cnt = 0;
      exp_ovr = 1'b0;
      exp_tout = 1'b0;
      exp_end = -1;
      from = s;
      f = -1;
      fin = 1'b0;
      guard = 0;
      while (!fin && guard < 1000) begin
         guard++;
         if (f < 0) begin
            f = next_tick(s, p, from);
            if (stop_c >= from && stop_c <= f) begin
               exp_end = stop_c + 1;
               fin = 1'b1;
            end else begin
               f = f + 1;
            end
         end
         if (!fin) begin
            exp_str.push_back(f);
            if (!resp || (t != 0 && l > t)) begin
               for (int c = f + 1; c <= f + t; c++)
                  if (is_tick(s, p, c)) exp_ovr = 1'b1;
               exp_tout = 1'b1;
               exp_end = f + t + 1;
               fin = 1'b1;
            end else begin
               d = f + l;
               for (int c = f + 1; c < d; c++)
                  if (is_tick(s, p, c)) exp_ovr = 1'b1;
               if (cnt != 65535) cnt++;
               if ((n != 0 && cnt == n) ||
                   (stop_c >= f && stop_c <= d)) begin
                  exp_end = d + 1;
                  fin = 1'b1;
               end else if (is_tick(s, p, d)) begin
                  f = d + 1;
               end else begin
                  from = d + 1;
                  f = -1;
               end
            end
         end
      end
      exp_cnt = cnt;
   endtask

   // One run: stop_rel -1 none, -2 together with start, else cycles after s.
   task automatic run_case(input string nm, input int p, input int n,
                           input int t, input int l, input int stop_rel,
                           input bit resp, input bit noise);
      int s;
      int c;
      int stop_c;
      int due;
      int act_end;
      int budget;
      int act_str[$];
      logic busy_s;
      logic busy_after;
      logic [15:0] cnt_end;
      logic ovr_end;
      logic to_end;
      @(negedge clk);
      start_i  = 1'b1;
      stop_i   = (stop_rel == -2);
      period_i = 29'(p);
      nsamp_i  = 16'(n);
      tout_i   = 16'(t);
      s = cyc + 1;
      stop_c = (stop_rel < 0) ? -1 : s + stop_rel;
      model(s, p, n, t, l, stop_c, resp);
      due = -1;
      act_end = -1;
      busy_s = 1'bx;
      busy_after = 1'b1;
      cnt_end = 'x;
      ovr_end = 1'bx;
      to_end = 1'bx;
      budget = exp_end - s + 20;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         c = cyc;
         if (c == s) busy_s = busy_o;
         if (spi_start_o) begin
            act_str.push_back(c);
            due = c + l;
         end
         if (done_o && act_end < 0) begin
            act_end = c;
            cnt_end = cnt_o;
            ovr_end = ovr_o;
            to_end  = tout_o;
         end
         if (act_end >= 0 && c == act_end + 1) busy_after = busy_o;
         start_i = noise && (c <= exp_end) && ($urandom_range(0, 2) == 0);
         if (noise) begin
            period_i = 29'($urandom);
            nsamp_i  = 16'($urandom);
            tout_i   = 16'($urandom);
         end
         stop_i = (c == stop_c);
         spi_done_i = resp && (c == due);
         if (act_end >= 0 && c > act_end) break;
      end
      start_i = 1'b0;
      stop_i = 1'b0;
      spi_done_i = 1'b0;
      checks++;
      if (busy_s !== 1'b1) begin
         errors++;
         $display("FAIL %s busy_at_start: got %b want 1", nm, busy_s);
      end
      checks++;
      if (act_end != exp_end) begin
         errors++;
         $display("FAIL %s done_time: got %0d want %0d (rel start)",
                  nm, act_end - s, exp_end - s);
      end
      checks++;
      if (act_str.size() != exp_str.size()) begin
         errors++;
         $display("FAIL %s strobe_count: got %0d want %0d",
                  nm, act_str.size(), exp_str.size());
      end
      foreach (exp_str[i]) begin
         if (i < act_str.size()) begin
            checks++;
            if (act_str[i] != exp_str[i]) begin
               errors++;
               $display("FAIL %s strobe%0d_time: got %0d want %0d",
                        nm, i, act_str[i] - s, exp_str[i] - s);
            end
         end
      end
      checks++;
      if (cnt_end !== 16'(exp_cnt)) begin
         errors++;
         $display("FAIL %s cnt: got %0d want %0d", nm, cnt_end, exp_cnt);
      end
      checks++;
      if (ovr_end !== exp_ovr) begin
         errors++;
         $display("FAIL %s ovr: got %b want %b", nm, ovr_end, exp_ovr);
      end
      checks++;
      if (to_end !== exp_tout) begin
         errors++;
         $display("FAIL %s tout: got %b want %b", nm, to_end, exp_tout);
      end
      checks++;
      if (busy_after !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_after_done: got %b want 0", nm, busy_after);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({spi_start_o, busy_o, done_o, ovr_o, tout_o, cnt_o} !== 21'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b want 0",
                  {spi_start_o, busy_o, done_o, ovr_o, tout_o, cnt_o});
      end
      rst_i = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({spi_start_o, busy_o, done_o, cnt_o} !== 19'd0) begin
         errors++;
         $display("FAIL idle_after_reset: got %b want 0",
                  {spi_start_o, busy_o, done_o, cnt_o});
      end
   endtask

   task automatic test_periodic();
      run_case("t1_periodic", 9, 3, 0, 4, -1, 1'b1, 1'b0);
   endtask

   task automatic test_ignored();
      int prev;
      prev = exp_cnt;
      @(negedge clk);
      spi_done_i = 1'b1;
      @(negedge clk);
      spi_done_i = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy_o, spi_start_o, cnt_o} !== {2'b00, 16'(prev)}) begin
         errors++;
         $display("FAIL idle_done_ignored: got %b/%b/%0d want 0/0/%0d",
                  busy_o, spi_start_o, cnt_o, prev);
      end
      run_case("t6_busy_start", 3, 4, 0, 2, -1, 1'b1, 1'b1);
      run_case("start_with_stop", 2, 2, 0, 3, -2, 1'b1, 1'b0);
   endtask

   task automatic test_stop();
      run_case("t2_stop_wait_done", 4, 0, 0, 6, 8, 1'b1, 1'b0);
      run_case("stop_wait_tick", 10, 0, 0, 2, 3, 1'b1, 1'b0);
      run_case("stop_fire", 5, 0, 0, 3, 6, 1'b1, 1'b0);
   endtask

   task automatic test_overrun();
      run_case("t3_overrun", 2, 4, 0, 6, -1, 1'b1, 1'b0);
      run_case("zero_period", 0, 3, 0, 1, -1, 1'b1, 1'b0);
   endtask

   task automatic test_timeout();
      run_case("t4_timeout", 3, 2, 5, 1, -1, 1'b0, 1'b0);
      run_case("tout_boundary", 1, 2, 3, 3, -1, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid_run();
      bit seen;
      @(negedge clk);
      start_i  = 1'b1;
      stop_i   = 1'b0;
      period_i = 29'd0;
      nsamp_i  = 16'd0;
      tout_i   = 16'd0;
      @(negedge clk);
      start_i = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         seen = spi_start_o;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL t5_first_strobe: got none want strobe");
      end
      repeat (3) @(negedge clk);
      checks++;
      if ({busy_o, ovr_o} !== 2'b11) begin
         errors++;
         $display("FAIL t5_pre_reset: got %b want 11", {busy_o, ovr_o});
      end
      #2 rst_i = 1'b1;
      #1;
      checks++;
      if ({spi_start_o, busy_o, done_o, ovr_o, tout_o, cnt_o} !== 21'd0) begin
         errors++;
         $display("FAIL t5_async_reset: got %b want 0",
                  {spi_start_o, busy_o, done_o, ovr_o, tout_o, cnt_o});
      end
      @(negedge clk);
      rst_i = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy_o, done_o} !== 2'b00) begin
         errors++;
         $display("FAIL t5_after_reset: got %b want 00", {busy_o, done_o});
      end
      run_case("t5_clean_rerun", 9, 3, 0, 4, -1, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      int p;
      int l;
      int n;
      int t;
      int sr;
      for (int i = 0; i < 25; i++) begin
         p = $urandom_range(0, 12);
         l = $urandom_range(1, 8);
         n = $urandom_range(0, 5);
         t = 0;
         if ($urandom_range(0, 1) == 1) t = $urandom_range(1, 10);
         sr = -1;
         if ($urandom_range(0, 2) == 0) sr = $urandom_range(0, 60);
         if (n == 0 && sr < 0 && !(t != 0 && l > t)) sr = $urandom_range(0, 60);
         run_case($sformatf("rand%0d", i), p, n, t, l, sr, 1'b1,
                  $urandom_range(0, 1) == 1);
      end
   endtask

   initial begin
      rst_i      = 1'b1;
      start_i    = 1'b0;
      stop_i     = 1'b0;
      spi_done_i = 1'b0;
      period_i   = '0;
      nsamp_i    = '0;
      tout_i     = '0;
      exp_cnt    = 0;
      test_reset();
      test_periodic();
      test_ignored();
      test_stop();
      test_overrun();
      test_timeout();
      test_reset_mid_run();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
